// File: rtl/hc153_scan_mux_if.sv
// Data/control bundle for hc153_scan_mux: mux inputs, select/mode controls
// and the registered outputs with their step/wrap strobes.
interface hc153_scan_mux_if #(
  parameter int W    = 1,
  parameter int SELW = 2,
  parameter int NCH  = 2
);
  logic [NCH*(2**SELW)*W-1:0] I;
  logic [SELW-1:0]            S;
  logic [NCH-1:0]             EN_N;
  logic                       MODE;
  logic                       HOLD;
  logic [NCH*W-1:0]           Y;
  logic [SELW-1:0]            SEL_Q;
  logic                       STEP;
  logic                       WRAP;

  modport master (output I, S, EN_N, MODE, HOLD, input Y, SEL_Q, STEP, WRAP);
  modport slave  (input I, S, EN_N, MODE, HOLD, output Y, SEL_Q, STEP, WRAP);
endinterface

// File: rtl/hc153_scan_mux.sv
// NCH-channel registered 2**SELW:1 selector with manual / auto-scan select.
// Auto-scan walks the shared index, dwelling DWELL cycles per index; STEP
// and WRAP flag the first output cycle of a freshly advanced index.

// One channel: enable-gated select of one of 2**SELW words.
module hc153_lane #(
  parameter int W    = 1,
  parameter int SELW = 2
) (
  input  logic [(2**SELW)*W-1:0] d,
  input  logic [SELW-1:0]        sel,
  input  logic                   en_n,
  output logic [W-1:0]           y
);
  logic [2**SELW-1:0][W-1:0] dv;
  assign dv = d;

  // Disabled channel outputs zero; otherwise the selected word.
  always_comb begin
    y = '0;
    if (!en_n) y = dv[sel];
  end
endmodule

module hc153_scan_mux #(
  parameter int W     = 1,
  parameter int SELW  = 2,
  parameter int NCH   = 2,
  parameter int DWELL = 1
) (
  input  logic             CLK,
  input  logic             RST,
  hc153_scan_mux_if.slave  bus
);
  localparam int N   = 2**SELW;
  localparam int DCW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DCW-1:0] DLAST = DCW'(DWELL - 1);

  typedef enum logic {MANUAL, SCAN} state_t;

  state_t                   state_q, state_d;
  logic [SELW-1:0]          idx_q, idx_d;
  logic [DCW-1:0]           dcnt_q, dcnt_d;
  logic [NCH-1:0][W-1:0]    y_q, y_d;
  logic [SELW-1:0]          sel_q, sel_d;
  // adv/wrap delayed twice so the strobe lines up with SEL_Q showing the new idx
  logic [1:0]               adv_pipe_q, adv_pipe_d;
  logic [1:0]               wrap_pipe_q, wrap_pipe_d;
  logic [SELW-1:0]          sel_eff;
  logic                     adv, wrap;

  assign sel_eff = (state_q == SCAN) ? idx_q : bus.S;

  for (genvar c = 0; c < NCH; c++) begin : g_lane
    hc153_lane #(.W(W), .SELW(SELW)) u_lane (
      .d    (bus.I[c*N*W +: N*W]),
      .sel  (sel_eff),
      .en_n (bus.EN_N[c]),
      .y    (y_d[c])
    );
  end

  // Mode FSM, dwell counter and scan index advance.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dcnt_d  = dcnt_q;
    adv     = 1'b0;
    wrap    = 1'b0;
    case (state_q)
      MANUAL: begin
        if (bus.MODE) begin
          // entry load, not an advance: no strobe
          state_d = SCAN;
          idx_d   = bus.S;
          dcnt_d  = '0;
        end
      end
      SCAN: begin
        if (!bus.MODE) begin
          // exit beats a coinciding dwell expiry
          state_d = MANUAL;
          dcnt_d  = '0;
        end else if (!bus.HOLD) begin
          if (dcnt_q == DLAST) begin
            adv    = 1'b1;
            wrap   = (idx_q == {SELW{1'b1}});
            dcnt_d = '0;
            idx_d  = idx_q + 1'b1;
          end else begin
            dcnt_d = dcnt_q + 1'b1;
          end
        end
      end
      default: state_d = MANUAL;
    endcase
  end

  // Output data, select echo and strobe pipeline next values.
  always_comb begin
    sel_d       = sel_eff;
    adv_pipe_d  = {adv_pipe_q[0], adv};
    wrap_pipe_d = {wrap_pipe_q[0], wrap};
  end

  // State and output registers; synchronous reset clears everything.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= MANUAL;
      idx_q       <= '0;
      dcnt_q      <= '0;
      y_q         <= '0;
      sel_q       <= '0;
      adv_pipe_q  <= '0;
      wrap_pipe_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      dcnt_q      <= dcnt_d;
      y_q         <= y_d;
      sel_q       <= sel_d;
      adv_pipe_q  <= adv_pipe_d;
      wrap_pipe_q <= wrap_pipe_d;
    end
  end

  assign bus.Y     = y_q;
  assign bus.SEL_Q = sel_q;
  assign bus.STEP  = adv_pipe_q[1];
  assign bus.WRAP  = wrap_pipe_q[1];
endmodule

// File: tb/tb_hc153_scan_mux.sv
// Bench for hc153_scan_mux: three DUTs (DWELL=1,2,3) share one stimulus;
// a cycle model pushes expected outputs to a scoreboard, popped after each
// edge. Directed constant checks cover the reset, manual and scan scenarios.
module tb_hc153_scan_mux;
  typedef struct packed {
    logic [1:0] y;
    logic [1:0] sel;
    logic       step;
    logic       wrap;
  } exp_t;
  typedef exp_t [2:0] trio_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] i_v;
  logic [1:0] s_v, en_v;
  logic       mode_v, hold_v;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_n   = 0;

  trio_t sb[$];
  trio_t last_act;

  int m_st[3], m_idx[3], m_dcnt[3], m_p1s[3], m_p1w[3];

  always #5 clk = ~clk;

  hc153_scan_mux_if #(.W(1), .SELW(2), .NCH(2)) ifa ();
  hc153_scan_mux_if #(.W(1), .SELW(2), .NCH(2)) ifb ();
  hc153_scan_mux_if #(.W(1), .SELW(2), .NCH(2)) ifc ();

  assign ifa.I = i_v;   assign ifb.I = i_v;   assign ifc.I = i_v;
  assign ifa.S = s_v;   assign ifb.S = s_v;   assign ifc.S = s_v;
  assign ifa.EN_N = en_v; assign ifb.EN_N = en_v; assign ifc.EN_N = en_v;
  assign ifa.MODE = mode_v; assign ifb.MODE = mode_v; assign ifc.MODE = mode_v;
  assign ifa.HOLD = hold_v; assign ifb.HOLD = hold_v; assign ifc.HOLD = hold_v;

  hc153_scan_mux #(.W(1), .SELW(2), .NCH(2), .DWELL(1)) u_d1 (.CLK(clk), .RST(rst), .bus(ifa));
  hc153_scan_mux #(.W(1), .SELW(2), .NCH(2), .DWELL(2)) u_d2 (.CLK(clk), .RST(rst), .bus(ifb));
  hc153_scan_mux #(.W(1), .SELW(2), .NCH(2), .DWELL(3)) u_d3 (.CLK(clk), .RST(rst), .bus(ifc));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc_n, got, exp);
    end
  endtask

  // Reference model: expected outputs after the coming edge for DUT k.
  function automatic exp_t model_step(input int k);
    exp_t e;
    int   dw, sel, adv, wr;
    dw  = k + 1;
    sel = (m_st[k] != 0) ? m_idx[k] : int'(s_v);
    e.y[0] = en_v[0] ? 1'b0 : i_v[sel];
    e.y[1] = en_v[1] ? 1'b0 : i_v[4 + sel];
    e.sel  = sel[1:0];
    e.step = m_p1s[k][0];
    e.wrap = m_p1w[k][0];
    adv = 0;
    wr  = 0;
    if (rst) begin
      e = '0;
      m_st[k] = 0; m_idx[k] = 0; m_dcnt[k] = 0;
    end else if (m_st[k] == 0) begin
      if (mode_v) begin
        m_st[k] = 1; m_idx[k] = int'(s_v); m_dcnt[k] = 0;
      end
    end else if (!mode_v) begin
      m_st[k] = 0; m_dcnt[k] = 0;
    end else if (!hold_v) begin
      if (m_dcnt[k] == dw - 1) begin
        adv = 1;
        wr  = (m_idx[k] == 3) ? 1 : 0;
        m_dcnt[k] = 0;
        m_idx[k]  = (m_idx[k] + 1) % 4;
      end else begin
        m_dcnt[k] = m_dcnt[k] + 1;
      end
    end
    m_p1s[k] = adv;
    m_p1w[k] = wr;
    return e;
  endfunction

  // One clock: push expectations, advance, pop and compare every DUT.
  task automatic cyc();
    trio_t t, x;
    for (int k = 0; k < 3; k++) t[k] = model_step(k);
    sb.push_back(t);
    @(posedge clk);
    #1;
    cyc_n++;
    last_act[0] = {ifa.Y, ifa.SEL_Q, ifa.STEP, ifa.WRAP};
    last_act[1] = {ifb.Y, ifb.SEL_Q, ifb.STEP, ifb.WRAP};
    last_act[2] = {ifc.Y, ifc.SEL_Q, ifc.STEP, ifc.WRAP};
    x = sb.pop_front();
    for (int k = 0; k < 3; k++)
      chk($sformatf("sb_dwell%0d", k + 1), 32'(last_act[k]), 32'(x[k]));
  endtask

  logic [1:0] y_man [4];
  logic [1:0] y_dis [4];
  logic [1:0] sc_sel [11];
  logic       sc_stp [11];
  logic       sc_wrp [11];

  initial begin
    y_man  = '{2'b10, 2'b01, 2'b01, 2'b10};
    y_dis  = '{2'b10, 2'b00, 2'b00, 2'b10};
    sc_sel = '{2, 2, 2, 2, 3, 3, 3, 0, 0, 0, 1};
    sc_stp = '{0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1};
    sc_wrp = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};

    rst = 1'b1; i_v = 8'hff; s_v = 2'd0; en_v = 2'b00; mode_v = 1'b0; hold_v = 1'b0;
    for (int k = 0; k < 3; k++) begin
      m_st[k] = 0; m_idx[k] = 0; m_dcnt[k] = 0; m_p1s[k] = 0; m_p1w[k] = 0;
    end

    // reset with all-ones inputs
    for (int n = 0; n < 2; n++) begin
      cyc();
      for (int k = 0; k < 3; k++) chk("rst_outputs", 32'(last_act[k]), 32'd0);
    end
    rst = 1'b0; s_v = 2'd1;
    cyc();
    chk("rst_release_y", 32'(last_act[0].y), 32'd3);
    chk("rst_release_sel", 32'(last_act[0].sel), 32'd1);

    // manual sweep, then ch0 disabled
    i_v = 8'b1001_0110;
    for (int s = 0; s < 4; s++) begin
      s_v = 2'(s); cyc();
      chk("manual_y", 32'(last_act[0].y), 32'(y_man[s]));
    end
    en_v = 2'b01;
    for (int s = 0; s < 4; s++) begin
      s_v = 2'(s); cyc();
      chk("manual_en_y", 32'(last_act[0].y), 32'(y_dis[s]));
    end
    en_v = 2'b00;

    // auto scan from S=2 (DWELL=3 checked against fixed sequence)
    rst = 1'b1; cyc(); rst = 1'b0;
    s_v = 2'd2; mode_v = 1'b1;
    for (int n = 0; n < 11; n++) begin
      cyc();
      chk("scan_sel", 32'(last_act[2].sel), 32'(sc_sel[n]));
      chk("scan_step", 32'(last_act[2].step), 32'(sc_stp[n]));
      chk("scan_wrap", 32'(last_act[2].wrap), 32'(sc_wrp[n]));
    end

    // hold mid-dwell, then release
    hold_v = 1'b1;
    for (int n = 0; n < 5; n++) begin
      cyc();
      chk("hold_step", 32'(last_act[2].step), 32'd0);
    end
    hold_v = 1'b0;
    for (int n = 0; n < 6; n++) cyc();

    // mode exit at various dwell phases
    for (int n = 0; n < 6; n++) begin
      mode_v = 1'b0; s_v = 2'(n); cyc(); cyc();
      mode_v = 1'b1; for (int j = 0; j <= n; j++) cyc();
    end

    // reset mid-scan, re-entry with MODE still high
    for (int n = 0; n < 4; n++) cyc();
    rst = 1'b1; cyc();
    for (int k = 0; k < 3; k++) chk("rst_midscan", 32'(last_act[k]), 32'd0);
    rst = 1'b0; s_v = 2'd3;
    cyc();
    chk("reentry_sel", 32'(last_act[2].sel), 32'd3);
    for (int n = 0; n < 8; n++) cyc();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      i_v    = 8'($urandom);
      s_v    = 2'($urandom);
      en_v   = 2'($urandom);
      hold_v = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) mode_v = ~mode_v;
      rst    = ($urandom_range(0, 49) == 0);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
